// File: rtl/gmii_mac_tx.sv
`default_nettype none
// ============================================================================
// Module   : gmii_mac_tx
// Purpose  : MAC-side GMII transmitter. Converts an 8-bit AXI-stream frame
//            payload into a GMII transmit stream. It prepends 7x 0x55 plus the
//            0xD5 SFD, optionally pads short payloads with 0x00, and appends
//            the Ethernet FCS (reflected CRC-32, LSB first). It then holds off
//            for IFG idle cycles before the next frame can start.
// Ports    :
//   clk             in   transmit clock (GTX domain)
//   rst_n           in   asynchronous active-low reset
//   s_axis_tdata    in   [7:0] payload byte
//   s_axis_tvalid   in   payload byte valid
//   s_axis_tready   out  payload byte accepted when tvalid & tready
//   s_axis_tlast    in   last payload byte of the frame
//   s_axis_tuser    in   frame error flag, sampled with tlast
//   gmii_txd        out  [7:0] GMII transmit data (registered)
//   gmii_tx_en      out  GMII transmit enable (registered)
//   gmii_tx_er      out  GMII transmit error (registered)
//   start_packet    out  one-cycle pulse while SFD is on gmii_txd
//   error_underflow out  one-cycle pulse on a mid-frame source underflow
// Revision : 1.0 - initial release
// ============================================================================
module gmii_mac_tx #(
   parameter int ENABLE_PADDING   = 1,
   parameter int MIN_FRAME_LENGTH = 64,
   parameter int IFG              = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       start_packet,
   output logic       error_underflow
);

   // Payload length (bytes, FCS excluded) that padding tops a frame up to.
   localparam int          PAD_BYTES  = (MIN_FRAME_LENGTH > 4) ? (MIN_FRAME_LENGTH - 4) : 0;
   localparam logic [15:0] PAD_TARGET = 16'(PAD_BYTES);
   localparam logic [7:0]  IFG_LAST   = 8'(IFG - 1);
   localparam logic        PAD_EN     = (ENABLE_PADDING != 0);

   localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY_R = 32'hEDB8_8320;   // 0x04C11DB7 bit-reversed

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_PAYLOAD  = 3'd2,
      ST_PAD      = 3'd3,
      ST_FCS      = 3'd4,
      ST_IFG      = 3'd5,
      ST_DRAIN    = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  phase_q, phase_d;     // preamble index, FCS byte index, IFG count
   logic [31:0] crc_q, crc_d;
   logic [15:0] count_q, count_d;     // payload + pad bytes sent, saturating
   logic [7:0]  txd_q, txd_d;
   logic        tx_en_q, tx_en_d;
   logic        tx_er_q, tx_er_d;
   logic        tready_q, tready_d;
   logic        start_q, start_d;
   logic        underflow_q, underflow_d;

   logic        w_accept;
   logic [15:0] w_count_inc;
   logic [31:0] w_fcs;

   // One byte of the LSB-first (reflected) CRC-32 update.
   function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                            input logic [7:0]  data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
      end
      return c;
   endfunction

   assign w_accept    = s_axis_tvalid & tready_q;
   assign w_count_inc = (count_q == 16'hFFFF) ? count_q : (count_q + 16'd1);
   assign w_fcs       = ~crc_q;

   // ------------------------------------------------------------------------
   // Next-state and next-output logic. Every GMII output is the registered
   // version of what this block computes, so bytes hit the wire one cycle
   // after the state that produced them.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      crc_d       = crc_q;
      count_d     = count_q;
      txd_d       = 8'h00;
      tx_en_d     = 1'b0;
      tx_er_d     = 1'b0;
      start_d     = 1'b0;
      underflow_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Spending one cycle here to detect tvalid is what makes the
            // back-to-back gap IFG+1 cycles.
            crc_d   = CRC_INIT;
            count_d = 16'd0;
            phase_d = 8'd0;
            if (s_axis_tvalid) begin
               state_d = ST_PREAMBLE;
            end
         end

         ST_PREAMBLE: begin
            tx_en_d = 1'b1;
            if (phase_q == 8'd7) begin
               txd_d   = 8'hD5;
               start_d = 1'b1;
               phase_d = 8'd0;
               state_d = ST_PAYLOAD;
            end else begin
               txd_d   = 8'h55;
               phase_d = phase_q + 8'd1;
            end
         end

         ST_PAYLOAD: begin
            tx_en_d = 1'b1;
            if (w_accept) begin
               txd_d   = s_axis_tdata;
               crc_d   = crc_byte(crc_q, s_axis_tdata);
               count_d = w_count_inc;
               if (s_axis_tlast) begin
                  tx_er_d = s_axis_tuser;
                  phase_d = 8'd0;
                  if (PAD_EN && (w_count_inc < PAD_TARGET)) begin
                     state_d = ST_PAD;
                  end else begin
                     state_d = ST_FCS;
                  end
               end
            end else begin
               // Source ran dry mid-frame: poison the frame on the wire and
               // discard the rest of it without an FCS.
               tx_er_d     = 1'b1;
               underflow_d = 1'b1;
               state_d     = ST_DRAIN;
            end
         end

         ST_PAD: begin
            tx_en_d = 1'b1;
            crc_d   = crc_byte(crc_q, 8'h00);
            count_d = w_count_inc;
            if (w_count_inc >= PAD_TARGET) begin
               phase_d = 8'd0;
               state_d = ST_FCS;
            end
         end

         ST_FCS: begin
            tx_en_d = 1'b1;
            case (phase_q[1:0])
               2'd0:    txd_d = w_fcs[7:0];
               2'd1:    txd_d = w_fcs[15:8];
               2'd2:    txd_d = w_fcs[23:16];
               default: txd_d = w_fcs[31:24];
            endcase
            if (phase_q[1:0] == 2'd3) begin
               phase_d = 8'd0;
               state_d = ST_IFG;
            end else begin
               phase_d = phase_q + 8'd1;
            end
         end

         ST_IFG: begin
            if (phase_q == IFG_LAST) begin
               phase_d = 8'd0;
               crc_d   = CRC_INIT;
               count_d = 16'd0;
               state_d = ST_IDLE;
            end else begin
               phase_d = phase_q + 8'd1;
            end
         end

         ST_DRAIN: begin
            if (w_accept && s_axis_tlast) begin
               phase_d = 8'd0;
               state_d = ST_IFG;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // tready is registered alongside the data path: it rises together with
      // the SFD so the first payload byte follows the SFD with no bubble.
      tready_d = (state_d == ST_PAYLOAD) || (state_d == ST_DRAIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         phase_q     <= 8'd0;
         crc_q       <= CRC_INIT;
         count_q     <= 16'd0;
         txd_q       <= 8'h00;
         tx_en_q     <= 1'b0;
         tx_er_q     <= 1'b0;
         tready_q    <= 1'b0;
         start_q     <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         crc_q       <= crc_d;
         count_q     <= count_d;
         txd_q       <= txd_d;
         tx_en_q     <= tx_en_d;
         tx_er_q     <= tx_er_d;
         tready_q    <= tready_d;
         start_q     <= start_d;
         underflow_q <= underflow_d;
      end
   end

   assign gmii_txd        = txd_q;
   assign gmii_tx_en      = tx_en_q;
   assign gmii_tx_er      = tx_er_q;
   assign s_axis_tready   = tready_q;
   assign start_packet    = start_q;
   assign error_underflow = underflow_q;

endmodule
`default_nettype wire
